// File: rtl/poly_eval_mem.sv
// poly_eval_mem: Horner p(x)/p'(x) evaluator with coefficient store and sign-magnitude result RAM.
// Optional derivative mode enabled by defining DERIV_EN.
module poly_eval_mem #(
  parameter int ADDR_W = 4,
  parameter int DEG    = 3,
  parameter int COEF_W = 4,
  parameter int ARG_W  = 3,
  parameter int RES_W  = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       coef_we,
  input  logic [ADDR_W-1:0]          coef_addr,
  input  logic [$clog2(DEG+1)-1:0]   coef_idx,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       op,
  input  logic [ARG_W-1:0]           arg,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [RES_W-1:0]           rd_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int KW = $clog2(DEG+1);
  localparam int AW = RES_W+ARG_W+COEF_W+2;
  localparam int MW = RES_W-1;
  localparam logic signed [AW-1:0] MAXV = AW'(2**(RES_W-1)-1);
  typedef enum logic [1:0] {IDLE, STEP, WRITE} state_t;
  state_t state, state_n;
  logic signed [COEF_W-1:0] coef [DEPTH][DEG+1];
  logic [RES_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  logic signed [ARG_W-1:0] arg_r;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc, nxt, term;
  logic signed [COEF_W-1:0] c;
  logic sat, sat_step, last;
  logic [MW-1:0] mag;
  assign c = coef[addr_r][k];
`ifdef DERIV_EN
  localparam int PW = KW+COEF_W+1;
  logic op_r;
  logic signed [PW-1:0] kc;
  assign kc = PW'($signed({1'b0, k})) * PW'(c);
  assign term = op_r ? AW'(kc) : AW'(c);
  assign last = op_r ? (k == KW'(1)) : (k == '0);
`else
  logic unused_op;
  assign unused_op = op;
  assign term = AW'(c);
  assign last = (k == '0);
`endif
  assign nxt = acc * AW'(arg_r) + term;
  assign sat_step = (nxt > MAXV) || (nxt < -MAXV);
  assign mag = sat ? '1 : (acc[AW-1] ? MW'(-acc) : acc[MW-1:0]);
  assign busy = (state != IDLE);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = STEP;
    else if (state == STEP && (sat_step || last)) state_n = WRITE;
    else if (state == WRITE) state_n = IDLE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
        for (int j = 0; j <= DEG; j++) coef[i][j] <= '0;
      end
      rd_data <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      sat <= 1'b0;
      acc <= '0;
      k <= '0;
      addr_r <= '0;
      arg_r <= '0;
`ifdef DERIV_EN
      op_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (rd_en) rd_data <= ram[rd_addr];
      for (int j = 0; j <= DEG; j++)
        if (coef_we && state == IDLE && coef_idx == KW'(j)) coef[coef_addr][j] <= coef_data;
      if (state == IDLE && start) begin
        addr_r <= addr;
        arg_r <= arg;
`ifdef DERIV_EN
        op_r <= op;
`endif
        acc <= '0;
        k <= KW'(DEG);
        sat <= 1'b0;
      end
      if (state == STEP) begin
        acc <= nxt;
        k <= k - 1'b1;
        sat <= sat_step;
      end
      // overflowed accumulator keeps its sign; magnitude is forced to all ones
      if (state == WRITE) begin
        ram[addr_r] <= {acc[AW-1], mag};
        done <= 1'b1;
        ovf <= sat;
      end
    end
  end
endmodule

// File: tb/tb_poly_eval_mem.sv
// tb_poly_eval_mem: scoreboard bench for poly_eval_mem with an integer reference model.
module tb_poly_eval_mem;
  logic CLK = 0, RST = 1, coef_we = 0, start = 0, op = 0, rd_en = 0;
  logic [3:0] coef_addr = 0, addr = 0, rd_addr = 0, coef_data = 0;
  logic [1:0] coef_idx = 0;
  logic [2:0] arg = 0;
  logic busy, done, ovf;
  logic [9:0] rd_data;
  typedef struct {int word; bit ov; int dcyc;} item_t;
  item_t evq[$];
  int rdq[$];
  int mram[16];
  int mcoef[16][4];
  int cyc = 0, checks = 0, failures = 0, ndone = 0;
  bit rd_pend = 0;
  item_t it;
  int e;
  always #5 CLK = ~CLK;
  poly_eval_mem dut (
    .CLK(CLK), .RST(RST), .coef_we(coef_we), .coef_addr(coef_addr), .coef_idx(coef_idx),
    .coef_data(coef_data), .start(start), .addr(addr), .op(op), .arg(arg), .busy(busy),
    .done(done), .ovf(ovf), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    rd_pend <= rd_en;
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (rd_pend) begin
      if (rdq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=read required=none");
      end else begin
        e = rdq.pop_front();
        chk("rd_data", int'(rd_data), e);
      end
    end
    if (done) begin
      ndone++;
      if (evq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=done required=none at cyc %0d", cyc);
      end else begin
        it = evq.pop_front();
        chk("ovf", int'(ovf), int'(it.ov));
        chk("done_latency", cyc, it.dcyc);
      end
    end
  end
  function automatic void model(input int a, input bit d, input int x,
                                output int word, output bit ov, output int steps);
    int acc = 0;
    ov = 0;
    steps = 0;
    for (int k = 3; k >= (d ? 1 : 0); k--) begin
      acc = acc * x + (d ? k : 1) * mcoef[a][k];
      steps++;
      if (acc > 511 || acc < -511) begin
        ov = 1;
        break;
      end
    end
    word = ov ? ((acc < 0) ? 1023 : 511) : ((acc < 0) ? (512 | -acc) : acc);
  endfunction
  task automatic wc(input int a, input int k, input int v, input bit apply);
    coef_we = 1; coef_addr = a[3:0]; coef_idx = k[1:0]; coef_data = v[3:0];
    if (apply) mcoef[a][k] = v;
    @(negedge CLK);
    coef_we = 0;
  endtask
  task automatic setc(input int a, input int c3, input int c2, input int c1, input int c0);
    wc(a, 3, c3, 1); wc(a, 2, c2, 1); wc(a, 1, c1, 1); wc(a, 0, c0, 1);
  endtask
  task automatic eval(input int a, input bit o, input int x);
    int w, s;
    bit ov, d;
`ifdef DERIV_EN
    d = o;
`else
    d = 0;
`endif
    model(a, d, x, w, ov, s);
    evq.push_back('{w, ov, cyc + s + 2});
    mram[a] = w;
    start = 1; addr = a[3:0]; op = o; arg = x[2:0];
    @(negedge CLK);
    start = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (evq.size() != 0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (evq.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=pending%0d required=0", evq.size());
      evq.delete();
    end
    @(negedge CLK);
  endtask
  task automatic rd1(input int a);
    rd_en = 1; rd_addr = a[3:0];
    rdq.push_back(mram[a]);
    @(negedge CLK);
    rd_en = 0;
    @(negedge CLK);
  endtask
  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = i[3:0];
      rdq.push_back(mram[i]);
      @(negedge CLK);
    end
    rd_en = 0;
    @(negedge CLK);
  endtask
  function automatic int rnd_coef();
    return int'($urandom_range(0, 15)) - 8;
  endfunction
  function automatic int rnd_arg();
    return int'($urandom_range(0, 7)) - 4;
  endfunction
  initial begin
    int n0, n, a;
    for (int i = 0; i < 16; i++) begin
      mram[i] = 0;
      for (int j = 0; j < 4; j++) mcoef[i][j] = 0;
    end
    repeat (2) @(negedge CLK);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    RST = 0;
    @(negedge CLK);
    read_all();
    setc(2, 1, -2, 3, -4);
    eval(2, 0, 2); wait_idle(); rd1(2);
    eval(2, 0, -2); wait_idle();
    chk("rd_hold", int'(rd_data), 2);
    rd1(2);
    eval(2, 1, -1); wait_idle(); rd1(2);
    setc(5, 7, -8, 7, -8);
    eval(5, 0, -4); wait_idle(); rd1(5);
    eval(2, 0, 1);
    wc(2, 0, 5, 0);
    wait_idle(); rd1(2);
    eval(2, 0, 1); wait_idle(); rd1(2);
    n0 = ndone;
    eval(2, 0, 2);
    @(negedge CLK);
    start = 1; addr = 4'd7; arg = 3'd3; op = 0;
    @(negedge CLK);
    start = 0;
    wait_idle();
    chk("one_done", ndone - n0, 1);
    rd1(7); rd1(2);
    setc(3, rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
    setc(4, 1, 1, 1, 1);
    eval(3, 0, 3);
    n = 0;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    eval(4, 0, 1);
    wait_idle(); rd1(3); rd1(4);
    for (int t = 0; t < 30; t++) begin
      a = int'($urandom_range(0, 15));
      setc(a, rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
      eval(a, 1'($urandom_range(0, 1)), rnd_arg());
      wait_idle();
      rd1(a);
    end
    read_all();
    eval(6, 0, 3);
    @(negedge CLK);
    RST = 1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    evq.delete();
    for (int i = 0; i < 16; i++) begin
      mram[i] = 0;
      for (int j = 0; j < 4; j++) mcoef[i][j] = 0;
    end
    @(negedge CLK);
    chk("rst_rd_data", int'(rd_data), 0);
    RST = 0;
    repeat (8) @(negedge CLK);
    read_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
